// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: round count, word/round-key widths,
// RCON table and the round-key slot position inside the expanded key.
package aes_pkg;

  localparam int NR  = 10;
  localparam int NK  = 4;
  localparam int RKW = 128;
  localparam int EKW = RKW * (NR + 1);

  typedef enum logic {
    IDLE,
    EXPAND
  } ks_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // MSB of round key i; round key 0 sits at the top of the expanded key
  function automatic int slot_msb(input int i);
    slot_msb = EKW - 1 - RKW * i;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational. Shared with the SubBytes stage.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[a];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock, start/busy/done
// handshake, expanded key held in 11 slots until overwritten.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [RKW-1:0]            key,
  output logic                      busy,
  output logic                      done,
  output logic                      key_valid,
  output logic [RKW*(NR+1)-1:0]     expanded_key
);

  ks_state_e      state, state_n;
  logic [3:0]     rnd, rnd_n;
  logic           busy_n, done_n, kv_n;
  logic           load, wr;

  logic [RKW-1:0] slots [NR+1];
  logic [RKW-1:0] prev_rk, next_rk;
  logic [31:0]    rot, sub, temp;
  logic [31:0]    w0, w1, w2, w3;

  // FSM / round counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      rnd       <= rnd_n;
      busy      <= busy_n;
      done      <= done_n;
      key_valid <= kv_n;
    end
  end

  always_comb begin
    state_n = state;
    rnd_n   = rnd;
    busy_n  = busy;
    done_n  = 1'b0;
    kv_n    = key_valid;
    load    = 1'b0;
    wr      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = EXPAND;
          rnd_n   = 4'd1;
          busy_n  = 1'b1;
          kv_n    = 1'b0;
          load    = 1'b1;
        end
      end
      EXPAND: begin
        wr    = 1'b1;
        rnd_n = rnd + 4'd1;
        if (rnd == 4'(NR)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          kv_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Previous round key is only meaningful while expanding (rnd in 1..NR)
  assign prev_rk = (state == EXPAND) ? slots[rnd - 4'd1] : '0;
  assign rot     = {prev_rk[23:0], prev_rk[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .a (rot[8*g +: 8]),
      .y (sub[8*g +: 8])
    );
  end

  assign temp    = sub ^ {rcon(rnd), 24'h0};
  assign w0      = prev_rk[127:96] ^ temp;
  assign w1      = prev_rk[95:64]  ^ w0;
  assign w2      = prev_rk[63:32]  ^ w1;
  assign w3      = prev_rk[31:0]   ^ w2;
  assign next_rk = {w0, w1, w2, w3};

  // Datapath: write the indexed slot
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) slots[i] <= '0;
    end else if (load) begin
      slots[0] <= key;
    end else if (wr) begin
      slots[rnd] <= next_rk;
    end
  end

  for (genvar i = 0; i <= NR; i++) begin : g_pack
    assign expanded_key[slot_msb(i) -: RKW] = slots[i];
  end

endmodule
